// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram_controller_pkg;

  // Access sequencing: IDLE waits for a request, LOW/HIGH move the two
  // halfwords, DONE is the single cycle in which the pipeline is released.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int          SRAM_DATA_W       = 16;
  localparam int          SRAM_ADDR_W       = 18;
  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;

  // Word index inside the SRAM: byte address relative to the mapped base,
  // with the byte offset and everything above the SRAM size discarded.
  function automatic logic [SRAM_ADDR_W-2:0] wordIndex(input logic [31:0] addr,
                                                       input logic [31:0] base);
    return (SRAM_ADDR_W-1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Serves 32-bit data-memory accesses from a 16-bit asynchronous SRAM as two
// halfword phases, holding ready low so the pipeline freezes meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  // Terminal value of the phase counter; each phase lasts WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  sram_state_t            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   isWrite_q, isWrite_d;
  logic [SRAM_ADDR_W-2:0] wordIdx_q, wordIdx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            readData_q, readData_d;

  logic                   lastCnt;
  logic                   driveDq;
  logic [SRAM_DATA_W-1:0] dqOut;
  logic                   sramWeN;
  logic [SRAM_ADDR_W-1:0] sramAddr;

  assign lastCnt = (cnt_q == CNT_LAST);

  // State, counter and latched request; reset aborts any access in flight
  // and clears the read buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      isWrite_q  <= 1'b0;
      wordIdx_q  <= '0;
      wdata_q    <= 32'd0;
      readData_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isWrite_q  <= isWrite_d;
      wordIdx_q  <= wordIdx_d;
      wdata_q    <= wdata_d;
      readData_q <= readData_d;
    end
  end

  // Next-state and SRAM pin control. The request is only looked at in IDLE;
  // after that the latched copies drive the access so it always completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isWrite_d  = isWrite_q;
    wordIdx_d  = wordIdx_q;
    wdata_d    = wdata_q;
    readData_d = readData_q;
    driveDq    = 1'b0;
    dqOut      = '0;
    sramWeN    = 1'b1;
    sramAddr   = '0;

    case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          isWrite_d = wr_en;
          wordIdx_d = wordIndex(address, ADDR_BASE);
          wdata_d   = write_data;
          cnt_d     = 4'd0;
          state_d   = LOW;
        end
      end

      LOW: begin
        sramAddr = {wordIdx_q, 1'b0};
        if (isWrite_q) begin
          sramWeN = 1'b0;
          driveDq = 1'b1;
          dqOut   = wdata_q[15:0];
        end
        if (lastCnt) begin
          cnt_d   = 4'd0;
          state_d = HIGH;
          if (!isWrite_q) begin
            readData_d[15:0] = SRAM_DQ;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      HIGH: begin
        sramAddr = {wordIdx_q, 1'b1};
        if (isWrite_q) begin
          sramWeN = 1'b0;
          driveDq = 1'b1;
          dqOut   = wdata_q[31:16];
        end
        if (lastCnt) begin
          cnt_d   = 4'd0;
          state_d = DONE;
          if (!isWrite_q) begin
            readData_d[31:16] = SRAM_DQ;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready     = ((state_q == IDLE) & ~rd_en & ~wr_en) | (state_q == DONE);
  assign read_data = readData_q;

  assign SRAM_DQ   = driveDq ? dqOut : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = sramAddr;
  assign SRAM_WE_N = sramWeN;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: one instance at the default wait
// count, one with single-cycle phases, each wired to a behavioural SRAM.
module tb_sram_controller;

  logic        clk;
  logic        rst;

  logic        rdEn0, wrEn0, rdEn1, wrEn1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  wire  [31:0] rdata0, rdata1;
  wire         ready0, ready1;
  wire  [15:0] dq0, dq1;
  wire  [17:0] sAddr0, sAddr1;
  wire         weN0, weN1;
  wire         ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1;

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
    logic [17:0] expAddr;
    bit          drop;
  } vec_t;

  typedef struct {
    int          sel;
    bit          isWrite;
    logic [31:0] expRead;
    logic [17:0] expAddr;
    logic [15:0] expLo;
    logic [15:0] expHi;
    int          expCycles;
    int          expWeLow;
    string       tag;
  } expect_t;

  expect_t     sbQ[$];
  vec_t        vecs[14];
  vec_t        v;

  int          testsRun;
  int          testsFailed;
  int          obsCycles;
  int          obsWeLow;
  logic [17:0] obsLowAddr;
  logic [17:0] obsHighAddr;
  bit          obsDone;

  sram_controller #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rdEn0), .wr_en(wrEn0),
    .address(addr0), .write_data(wdata0), .read_data(rdata0), .ready(ready0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sAddr0), .SRAM_WE_N(weN0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rdEn1), .wr_en(wrEn1),
    .address(addr1), .write_data(wdata1), .read_data(rdata1), .ready(ready1),
    .SRAM_DQ(dq1), .SRAM_ADDR(sAddr1), .SRAM_WE_N(weN1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: output data whenever write enable is high, store the
  // bus on each clock edge while write enable is low.
  assign dq0 = weN0 ? mem0[sAddr0] : 16'hzzzz;
  assign dq1 = weN1 ? mem1[sAddr1] : 16'hzzzz;

  always @(posedge clk) begin
    if (!weN0) mem0[sAddr0] <= dq0;
  end

  always @(posedge clk) begin
    if (!weN1) mem1[sAddr1] <= dq1;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic selReady(input int sel);
    return (sel != 0) ? ready1 : ready0;
  endfunction

  function automatic logic selWeN(input int sel);
    return (sel != 0) ? weN1 : weN0;
  endfunction

  function automatic logic [17:0] selAddr(input int sel);
    return (sel != 0) ? sAddr1 : sAddr0;
  endfunction

  function automatic logic [31:0] selRdata(input int sel);
    return (sel != 0) ? rdata1 : rdata0;
  endfunction

  function automatic logic [15:0] selMem(input int sel, input logic [17:0] idx);
    return (sel != 0) ? mem1[idx] : mem0[idx];
  endfunction

  task automatic driveReq(input int sel, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (sel != 0) begin
      rdEn1 = rd; wrEn1 = wr; addr1 = addr; wdata1 = wdata;
    end else begin
      rdEn0 = rd; wrEn0 = wr; addr0 = addr; wdata0 = wdata;
    end
  endtask

  // Issue one access from an IDLE cycle, follow it to DONE recording what the
  // SRAM pins did, then score it and step into the following IDLE cycle.
  task automatic applyStimulus(input int sel, input vec_t vec, input string tag);
    expect_t e;
    int      w;
    w           = (sel != 0) ? 1 : 2;
    e.sel       = sel;
    e.isWrite   = vec.wr;
    e.expRead   = vec.expRead;
    e.expAddr   = vec.expAddr;
    e.expLo     = vec.wdata[15:0];
    e.expHi     = vec.wdata[31:16];
    e.expCycles = 2 * w + 1;
    e.expWeLow  = vec.wr ? 2 * w : 0;
    e.tag       = tag;
    sbQ.push_back(e);

    driveReq(sel, vec.rd, vec.wr, vec.addr, vec.wdata);
    #1;
    check({tag, ".readyAtRequest"}, 32'(selReady(sel)), 32'd0);

    obsCycles   = 1;
    obsWeLow    = 0;
    obsLowAddr  = '0;
    obsHighAddr = '0;
    obsDone     = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (vec.drop && c == 1) begin
        driveReq(sel, 1'b0, 1'b0, ~vec.addr, ~vec.wdata);
        #1;
      end
      if (c == 1) obsLowAddr = selAddr(sel);
      if (c == w + 1) obsHighAddr = selAddr(sel);
      if (!selWeN(sel)) obsWeLow++;
      if (selReady(sel)) begin
        obsDone = 1'b1;
        break;
      end
      obsCycles++;
    end
    if (!obsDone) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s.timeout: ready never returned within 40 cycles", tag);
    end
    driveReq(sel, 1'b0, 1'b0, vec.addr, vec.wdata);
    checkOutput();
    @(posedge clk);
    #1;
    check({tag, ".readyIdle"}, 32'(selReady(sel)), 32'd1);
  endtask

  // Pop the oldest expectation and compare it with the access just finished.
  task automatic checkOutput();
    expect_t e;
    if (sbQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = sbQ.pop_front();
    check({e.tag, ".cycles"},   32'(obsCycles),       32'(e.expCycles));
    check({e.tag, ".readData"}, selRdata(e.sel),      e.expRead);
    check({e.tag, ".lowAddr"},  32'(obsLowAddr),      32'(e.expAddr));
    check({e.tag, ".highAddr"}, 32'(obsHighAddr),     32'(e.expAddr + 18'd1));
    check({e.tag, ".weLow"},    32'(obsWeLow),        32'(e.expWeLow));
    if (e.isWrite) begin
      check({e.tag, ".memLo"}, 32'(selMem(e.sel, e.expAddr)),         32'(e.expLo));
      check({e.tag, ".memHi"}, 32'(selMem(e.sel, e.expAddr + 18'd1)), 32'(e.expHi));
    end
  endtask

  // Main sequence: reset state, vector table, then multi-cycle corner cases.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0);

    //            rd    wr    address       write_data    expRead       expAddr     drop
    vecs[0]  = '{1'b0, 1'b1, 32'd1024,     32'hDEADBEEF, 32'h00000000, 18'h00000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024,     32'h00000000, 32'hDEADBEEF, 18'h00000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd1032,     32'h12345678, 32'hDEADBEEF, 18'h00004, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1032,     32'h00000000, 32'h12345678, 18'h00004, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'd1040,     32'hA5A5A5A5, 32'h12345678, 18'h00008, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'd1040,     32'h00000000, 32'hA5A5A5A5, 18'h00008, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h000803FE, 32'hCAFEF00D, 32'hA5A5A5A5, 18'h3FFFE, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h000803FC, 32'h00000000, 32'hCAFEF00D, 18'h3FFFE, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h00000000, 32'h0BADC0DE, 32'hCAFEF00D, 18'h3FE00, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h0BADC0DE, 18'h3FE00, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'd1048,     32'h11223344, 32'h0BADC0DE, 18'h0000C, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'd1048,     32'h00000000, 32'h11223344, 18'h0000C, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h00080404, 32'h600DF00D, 32'h11223344, 18'h00002, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'd1028,     32'h00000000, 32'h600DF00D, 18'h00002, 1'b0};

    #1;
    check("rst.ready",   32'(ready0), 32'd1);
    check("rst.rdata",   rdata0,      32'd0);
    check("rst.weN",     32'(weN0),   32'd1);
    check("rst.addr",    32'(sAddr0), 32'd0);
    check("rst.tieoffs", 32'({ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1}), 32'd0);
    rdEn0 = 1'b1;
    #1;
    check("rst.readyReq", 32'(ready0), 32'd0);
    rdEn0 = 1'b0;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, vecs[i], $sformatf("v%0d", i));
    end

    // Single-cycle phases: write then read, three frozen cycles each.
    v = '{1'b0, 1'b1, 32'd1024, 32'hFEEDFACE, 32'h00000000, 18'h00000, 1'b0};
    applyStimulus(1, v, "w1.write");
    v = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hFEEDFACE, 18'h00000, 1'b0};
    applyStimulus(1, v, "w1.read");

    // Back-to-back: request held through DONE is picked up in the next IDLE.
    driveReq(0, 1'b1, 1'b0, 32'd1032, 32'd0);
    obsDone = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready0) begin
        obsDone = 1'b1;
        break;
      end
    end
    check("b2b.firstDone", 32'(obsDone), 32'd1);
    @(posedge clk);
    #1;
    check("b2b.idleReady", 32'(ready0), 32'd0);
    obsCycles = 1;
    obsDone   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready0) begin
        obsDone = 1'b1;
        break;
      end
      obsCycles++;
    end
    check("b2b.cycles", 32'(obsCycles), 32'd5);
    check("b2b.rdata",  rdata0,         32'h12345678);
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    // Reset during the HIGH phase of a write.
    v = '{1'b0, 1'b1, 32'd1056, 32'hFFFF0000, 32'h12345678, 18'h00010, 1'b0};
    applyStimulus(0, v, "pre");
    driveReq(0, 1'b0, 1'b1, 32'd1056, 32'h55667788);
    repeat (3) @(posedge clk);
    #1;
    check("rstHigh.weBefore",   32'(weN0),   32'd0);
    check("rstHigh.addrBefore", 32'(sAddr0), 32'h11);
    #2 rst = 1'b1;
    #1;
    check("rstHigh.weN",   32'(weN0),   32'd1);
    check("rstHigh.addr",  32'(sAddr0), 32'd0);
    check("rstHigh.rdata", rdata0,      32'd0);
    check("rstHigh.ready", 32'(ready0), 32'd0);
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("rstHigh.readyIdle", 32'(ready0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("rstHigh.memLo", 32'(mem0[18'h10]), 32'h7788);
    check("rstHigh.memHi", 32'(mem0[18'h11]), 32'hFFFF);
    @(posedge clk);
    #1;
    v = '{1'b1, 1'b0, 32'd1056, 32'h00000000, 32'hFFFF7788, 18'h00010, 1'b0};
    applyStimulus(0, v, "postRst");

    check("sb.empty", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
